// File: rtl/fp_pack_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pack_if
//  Description : Handshake and data bundle between the FPU arithmetic core,
//                the fp_pack stage and the downstream result consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface fp_pack_if #(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 27
);
    logic              valid_i;
    logic              ready_o;
    logic              sign_i;
    logic [EXP_W-1:0]  exp_i;
    logic [MANT_W-1:0] mant_i;
    logic              is_nan_i;
    logic              is_inf_i;
    logic              valid_o;
    logic              ready_i;
    logic [31:0]       result_o;
    logic              overflow_o;
    logic              underflow_o;
    logic              inexact_o;

    // Pack stage side
    modport slave (
        input  valid_i, sign_i, exp_i, mant_i, is_nan_i, is_inf_i, ready_i,
        output ready_o, valid_o, result_o, overflow_o, underflow_o, inexact_o
    );

    // Producer / consumer side
    modport master (
        output valid_i, sign_i, exp_i, mant_i, is_nan_i, is_inf_i, ready_i,
        input  ready_o, valid_o, result_o, overflow_o, underflow_o, inexact_o
    );
endinterface
`default_nettype wire

// File: rtl/fp_pack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pack
//  Description : Normalize, round (nearest-even) and pack an unnormalized
//                sign/exponent/mantissa into an IEEE-754 single. Three
//                pipeline stages that shift together under valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_pack #(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 27
) (
    input  logic      clk,
    input  logic      rst,      // asynchronous, active-low
    fp_pack_if.slave  bus
);
    // Internal exponent carries two extra bits of headroom for the +1 of
    // carry normalization and the +1 of rounding carry.
    localparam int c_EW   = EXP_W + 2;
    localparam int c_NM_W = MANT_W - 1;         // normalized: no carry bit
    localparam int c_SH_W = $clog2(MANT_W);
    localparam int c_SIG_W = MANT_W - 3;        // hidden + fraction
    localparam logic signed [c_EW-1:0] c_E_ZERO = '0;
    localparam logic signed [c_EW-1:0] c_E_ONE  = c_EW'(1);
    localparam logic signed [c_EW-1:0] c_E_CAP  = c_EW'(MANT_W - 1);
    localparam logic signed [c_EW-1:0] c_E_MAX  = c_EW'(255);

    logic w_adv;

    // ---------------- stage 1 combinational: normalize ----------------
    logic signed [c_EW-1:0] w_e_in, w_e_n1, w_e_s1, w_lim, w_lz_ext, w_lsh_ext, w_rsh;
    logic [c_SH_W-1:0]      w_lz, w_lsh, w_rsh_c;
    logic [c_NM_W-1:0]      w_m_n1, w_m_s1, w_lost;

    // Leading-zero left shift (clamped at exp 1) or carry right shift, then denormalize
    always_comb begin
        w_e_in = $signed({{2{bus.exp_i[EXP_W-1]}}, bus.exp_i});
        w_lz   = c_SH_W'(c_NM_W);
        for (int i = 0; i < c_NM_W; i++) begin
            if (bus.mant_i[i]) w_lz = c_SH_W'(c_NM_W - 1 - i);
        end
        w_lz_ext  = $signed({{(c_EW-c_SH_W){1'b0}}, w_lz});
        w_lim     = w_e_in - c_E_ONE;
        w_lsh     = '0;
        w_m_n1    = bus.mant_i[c_NM_W-1:0];
        w_e_n1    = w_e_in;
        if (bus.mant_i[MANT_W-1]) begin
            w_m_n1    = bus.mant_i[MANT_W-1:1];
            w_m_n1[0] = bus.mant_i[1] | bus.mant_i[0];
            w_e_n1    = w_e_in + c_E_ONE;
        end else begin
            if (w_lim <= c_E_ZERO)    w_lsh = '0;
            else if (w_lim < w_lz_ext) w_lsh = w_lim[c_SH_W-1:0];
            else                       w_lsh = w_lz;
            w_m_n1 = bus.mant_i[c_NM_W-1:0] << w_lsh;
        end
        w_lsh_ext = $signed({{(c_EW-c_SH_W){1'b0}}, w_lsh});
        if (!bus.mant_i[MANT_W-1]) w_e_n1 = w_e_in - w_lsh_ext;

        w_rsh   = c_E_ONE - w_e_n1;
        w_rsh_c = (w_rsh > c_E_CAP) ? c_SH_W'(MANT_W - 1) : w_rsh[c_SH_W-1:0];
        w_lost  = '0;
        w_m_s1  = w_m_n1;
        w_e_s1  = w_e_n1;
        if (w_e_n1 <= c_E_ZERO) begin
            w_lost    = w_m_n1 & ~({c_NM_W{1'b1}} << w_rsh_c);
            w_m_s1    = w_m_n1 >> w_rsh_c;
            w_m_s1[0] = w_m_s1[0] | (|w_lost);
            w_e_s1    = c_E_ZERO;
        end
    end

    logic                   r1_v, r1_sign, r1_nan, r1_inf, r1_zero;
    logic signed [c_EW-1:0] r1_exp;
    logic [c_NM_W-1:0]      r1_mant;

    // Stage 1 register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1_v <= 1'b0; r1_sign <= 1'b0; r1_nan <= 1'b0; r1_inf <= 1'b0;
            r1_zero <= 1'b0; r1_exp <= '0; r1_mant <= '0;
        end else if (w_adv) begin
            r1_v    <= bus.valid_i;
            r1_sign <= bus.sign_i;
            r1_nan  <= bus.is_nan_i;
            r1_inf  <= bus.is_inf_i;
            r1_zero <= (bus.mant_i == '0);
            r1_exp  <= w_e_s1;
            r1_mant <= w_m_s1;
        end
    end

    // ---------------- stage 2 combinational: round nearest-even ----------------
    logic [c_SIG_W:0]       w_sum;
    logic                   w_up;
    logic [c_SIG_W-2:0]     w_frac2;
    logic signed [c_EW-1:0] w_e2;

    // Round on guard/sticky/lsb; renormalize a carry-out or subnormal promotion
    always_comb begin
        w_up    = r1_mant[1] & (r1_mant[0] | r1_mant[2]);
        w_sum   = {1'b0, r1_mant[c_NM_W-1:2]} + {{c_SIG_W{1'b0}}, w_up};
        w_frac2 = w_sum[c_SIG_W-2:0];
        w_e2    = r1_exp;
        if (w_sum[c_SIG_W]) begin
            w_frac2 = w_sum[c_SIG_W-1:1];
            w_e2    = r1_exp + c_E_ONE;
        end else if (r1_exp == c_E_ZERO && w_sum[c_SIG_W-1]) begin
            w_e2    = c_E_ONE;
        end
    end

    logic                   r2_v, r2_sign, r2_nan, r2_inf, r2_zero, r2_inx, r2_tiny;
    logic signed [c_EW-1:0] r2_exp;
    logic [c_SIG_W-2:0]     r2_frac;

    // Stage 2 register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r2_v <= 1'b0; r2_sign <= 1'b0; r2_nan <= 1'b0; r2_inf <= 1'b0;
            r2_zero <= 1'b0; r2_inx <= 1'b0; r2_tiny <= 1'b0;
            r2_exp <= '0; r2_frac <= '0;
        end else if (w_adv) begin
            r2_v    <= r1_v;
            r2_sign <= r1_sign;
            r2_nan  <= r1_nan;
            r2_inf  <= r1_inf;
            r2_zero <= r1_zero;
            r2_inx  <= r1_mant[1] | r1_mant[0];
            r2_tiny <= (r1_exp == c_E_ZERO);
            r2_exp  <= w_e2;
            r2_frac <= w_frac2;
        end
    end

    // ---------------- stage 3 combinational: pack and exceptions ----------------
    logic [31:0] w_res;
    logic        w_ovf, w_unf, w_inx;

    // Special-case precedence: NaN, infinity, zero, overflow, then normal packing
    always_comb begin
        w_res = {r2_sign, r2_exp[7:0], r2_frac};
        w_ovf = 1'b0;
        w_unf = r2_tiny & r2_inx;
        w_inx = r2_inx;
        if (r2_nan) begin
            w_res = 32'h7FC0_0000; w_unf = 1'b0; w_inx = 1'b0;
        end else if (r2_inf) begin
            w_res = {r2_sign, 8'hFF, 23'h0}; w_unf = 1'b0; w_inx = 1'b0;
        end else if (r2_zero) begin
            w_res = {r2_sign, 31'h0}; w_unf = 1'b0; w_inx = 1'b0;
        end else if (r2_exp >= c_E_MAX) begin
            w_res = {r2_sign, 8'hFF, 23'h0}; w_ovf = 1'b1; w_unf = 1'b0; w_inx = 1'b1;
        end
    end

    logic        r3_v, r3_ovf, r3_unf, r3_inx;
    logic [31:0] r3_res;

    // Output register; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r3_v <= 1'b0; r3_res <= '0; r3_ovf <= 1'b0; r3_unf <= 1'b0; r3_inx <= 1'b0;
        end else if (w_adv) begin
            r3_v   <= r2_v;
            r3_res <= w_res;
            r3_ovf <= w_ovf;
            r3_unf <= w_unf;
            r3_inx <= w_inx;
        end
    end

    assign w_adv           = !r3_v || bus.ready_i;
    assign bus.ready_o     = w_adv;
    assign bus.valid_o     = r3_v;
    assign bus.result_o    = r3_res;
    assign bus.overflow_o  = r3_ovf;
    assign bus.underflow_o = r3_unf;
    assign bus.inexact_o   = r3_inx;
endmodule
`default_nettype wire
